// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-side program counter, flag register, branch resolution and
// sticky halt. Optional branch performance counters are enabled by defining
// PC_PERF_CNT_EN (adds br_cnt/taken_cnt ports).
module pc_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic          stall,
  input  logic          alu_z,
  input  logic          alu_v,
  input  logic          alu_n,
  input  logic [DW-1:0] rs_data,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] pc_plus2,
  output logic          branch_taken,
  output logic [2:0]    flags,
`ifdef PC_PERF_CNT_EN
  output logic [15:0]   br_cnt,
  output logic [15:0]   taken_cnt,
`endif
  output logic          hlt
);

  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB = 4'b0001;
  localparam logic [OPW-1:0] OP_XOR = 4'b0010;
  localparam logic [OPW-1:0] OP_SLL = 4'b0100;
  localparam logic [OPW-1:0] OP_SRA = 4'b0101;
  localparam logic [OPW-1:0] OP_ROR = 4'b0110;
  localparam logic [OPW-1:0] OP_B   = 4'b1100;
  localparam logic [OPW-1:0] OP_BR  = 4'b1101;
  localparam logic [OPW-1:0] OP_HLT = 4'b1111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   pc_q, pc_d;
  logic [2:0]      flags_q, flags_d;

  logic [OPW-1:0]  opcode;
  logic [2:0]      ccc;
  logic [8:0]      imm;
  logic [DW-1:0]   b_off;
  logic [DW-1:0]   b_target;
  logic            flag_z, flag_v, flag_n;
  logic            cond_c;
  logic            is_branch_c;
  logic            is_hlt_c;
  logic            halted_c;
  logic            advance_c;

`ifdef PC_PERF_CNT_EN
  logic [15:0]     br_cnt_q, br_cnt_d;
  logic [15:0]     taken_cnt_q, taken_cnt_d;
`endif

  // Instruction field extraction and branch target arithmetic
  assign opcode      = instr[15:12];
  assign ccc         = instr[11:9];
  assign imm         = instr[8:0];
  assign b_off       = {{(DW-10){imm[8]}}, imm, 1'b0};
  assign pc_plus2    = pc_q + DW'(2);
  assign b_target    = pc_plus2 + b_off;

  assign flag_z      = flags_q[2];
  assign flag_v      = flags_q[1];
  assign flag_n      = flags_q[0];

  assign is_branch_c = (opcode == OP_B) || (opcode == OP_BR);
  assign is_hlt_c    = (opcode == OP_HLT);
  assign halted_c    = (state_q == ST_HALT);
  assign advance_c   = !stall && !halted_c;

  // Branch condition against the registered flags
  always_comb begin
    cond_c = 1'b0;
    unique case (ccc)
      3'b000: cond_c = !flag_z;
      3'b001: cond_c = flag_z;
      3'b010: cond_c = !flag_z && !flag_n;
      3'b011: cond_c = flag_n;
      3'b100: cond_c = flag_z || (!flag_z && !flag_n);
      3'b101: cond_c = flag_n || flag_z;
      3'b110: cond_c = flag_v;
      default: cond_c = 1'b1;
    endcase
  end

  assign branch_taken = is_branch_c && cond_c && !halted_c;
  assign hlt          = (is_hlt_c && !rst) || halted_c;
  assign pc           = pc_q;
  assign flags        = flags_q;

  // Next-state: halt FSM, PC selection and flag writes
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (advance_c) begin
      if (is_hlt_c) begin
        state_d = ST_HALT;
      end else if (branch_taken && (opcode == OP_B)) begin
        pc_d = b_target;
      end else if (branch_taken) begin
        pc_d = rs_data;
      end else begin
        pc_d = pc_plus2;
      end
      unique case (opcode)
        OP_ADD, OP_SUB: flags_d = {alu_z, alu_v, alu_n};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[2] = alu_z;
        default: flags_d = flags_q;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over stall and halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

`ifdef PC_PERF_CNT_EN
  // Saturating branch counters, advancing only on retiring edges
  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (advance_c && is_branch_c && (br_cnt_q != 16'hFFFF)) begin
      br_cnt_d = br_cnt_q + 16'd1;
    end
    if (advance_c && branch_taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q    <= 16'h0000;
      taken_cnt_q <= 16'h0000;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        stall;
  logic        alu_z, alu_v, alu_n;
  logic [15:0] rs_data;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        branch_taken;
  logic [2:0]  flags;
  logic        hlt;
`ifdef PC_PERF_CNT_EN
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;
`endif

  int n_asserts;
  int n_fails;

  pc_ctrl #(.RESET_PC(16'h0000), .DW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .stall        (stall),
    .alu_z        (alu_z),
    .alu_v        (alu_v),
    .alu_n        (alu_n),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .branch_taken (branch_taken),
    .flags        (flags),
`ifdef PC_PERF_CNT_EN
    .br_cnt       (br_cnt),
    .taken_cnt    (taken_cnt),
`endif
    .hlt          (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction's inputs, then settle for combinational checks
  task automatic drive(input logic [15:0] i, input logic s, input logic z,
                       input logic v, input logic n, input logic [15:0] rs);
    instr   = i;
    stall   = s;
    alu_z   = z;
    alu_v   = v;
    alu_n   = n;
    rs_data = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    rst = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset for two cycles
    tick();
    tick();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_flags", 16'(flags), 16'h0000);
    chk("reset_hlt", 16'(hlt), 16'h0000);

    // Sequential fetch with ADD
    rst = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("pc_plus2_0", pc_plus2, 16'h0002);
    tick();
    chk("pc_step1", pc, 16'h0002);
    tick();
    chk("pc_step2", pc, 16'h0004);
    tick();
    chk("pc_step3", pc, 16'h0006);

    // SUB writes all flags
    drive(16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("sub_pc", pc, 16'h0008);
    chk("sub_flags", 16'(flags), 16'h0004);

    // Stall for three cycles during ADD
    drive(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    tick();
    tick();
    chk("stall_pc", pc, 16'h0008);
    chk("stall_flags", 16'(flags), 16'h0004);

    // XOR updates Z only
    drive(16'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    chk("xor_pc", pc, 16'h000A);
    chk("xor_flags", 16'(flags), 16'h0000);

    // Set Z, then walk to 0010 with flag-holding opcode 0011
    drive(16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("sub2_flags", 16'(flags), 16'h0004);
    drive(16'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    tick();
    chk("hold_pc", pc, 16'h0010);
    chk("hold_flags", 16'(flags), 16'h0004);

    // B EQ forward, taken
    drive(16'hC204, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("beq_taken", 16'(branch_taken), 16'h0001);
    chk("beq_pc_plus2", pc_plus2, 16'h0012);
    tick();
    chk("beq_target", pc, 16'h001A);

    // Clear Z, then B EQ not taken
    drive(16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("xor2_flags", 16'(flags), 16'h0000);
    drive(16'hC204, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    chk("beq_not_taken", 16'(branch_taken), 16'h0000);
    tick();
    chk("beq_fallthru", pc, 16'h001E);

    // BR always to 0000, then B always with imm=-1 wraps back to 0000
    drive(16'hDE00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("br_taken", 16'(branch_taken), 16'h0001);
    tick();
    chk("br_zero", pc, 16'h0000);
    drive(16'hCFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("bback_pc_plus2", pc_plus2, 16'h0002);
    tick();
    chk("bback_target", pc, 16'h0000);
    drive(16'hDE00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
    tick();
    chk("br_1234", pc, 16'h1234);

    // Other condition codes with flags=000
    drive(16'hC400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ccc010_taken", 16'(branch_taken), 16'h0001);
    tick();
    chk("ccc010_pc", pc, 16'h1236);
    drive(16'hCC00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("ccc110_not", 16'(branch_taken), 16'h0000);
    tick();
    chk("ccc110_pc", pc, 16'h1238);
    drive(16'hDA00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555);
    chk("ccc101_not", 16'(branch_taken), 16'h0000);
    tick();
    chk("ccc101_pc", pc, 16'h123A);

    // BR passes odd bit 0; then BR to FFFE and PCS wraps
    drive(16'hDE00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F);
    tick();
    chk("br_odd", pc, 16'h0F0F);
    drive(16'hDE00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    tick();
    chk("br_fffe", pc, 16'hFFFE);
    drive(16'hE000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("pcs_plus2_wrap", pc_plus2, 16'h0000);
    tick();
    chk("pcs_wrap_pc", pc, 16'h0000);

    // Set V,N; B on N=1 lands at 0020; same-cycle alu_z must not matter
    drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    tick();
    chk("add_flags", 16'(flags), 16'h0003);
    drive(16'hC60E, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("bn_taken", 16'(branch_taken), 16'h0001);
    tick();
    chk("bn_target", pc, 16'h0020);
    chk("bn_flags", 16'(flags), 16'h0003);

    // HLT under stall: hlt is combinational only, latch stays clear
    drive(16'hF000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("hlt_stall_comb", 16'(hlt), 16'h0001);
    tick();
    chk("hlt_stall_pc", pc, 16'h0020);
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("hlt_not_latched", 16'(hlt), 16'h0000);

    // HLT unstalled: same-cycle hlt, then sticky
    drive(16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("hlt_comb", 16'(hlt), 16'h0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(16'hDE00 + 16'(k), 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
      chk("halted_bt", 16'(branch_taken), 16'h0000);
      chk("halted_hlt", 16'(hlt), 16'h0001);
      tick();
      chk("halted_pc", pc, 16'h0020);
    end
    chk("halted_flags", 16'(flags), 16'h0003);

    // Reset clears halt; simultaneous rst and HLT keeps hlt low
    rst = 1'b1;
    drive(16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_while_halted", 16'(hlt), 16'h0001);
    tick();
    chk("rst_hlt_same", 16'(hlt), 16'h0000);
    tick();
    rst = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("post_rst_pc", pc, 16'h0000);
    chk("post_rst_hlt", 16'(hlt), 16'h0000);
    chk("post_rst_flags", 16'(flags), 16'h0000);
    tick();
    chk("post_rst_run", pc, 16'h0002);

`ifdef PC_PERF_CNT_EN
    // One not-taken and one taken branch after reset
    drive(16'hC200, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(16'hDE00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100);
    tick();
    chk("br_cnt", br_cnt, 16'h0002);
    chk("taken_cnt", taken_cnt, 16'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Fetch-side program-counter and branch-resolution stage. It sits directly upstream of the instruction memory and produces the fetch address each cycle. It holds the architectural flag register (Z, V, N), evaluates B/BR conditions against the current instruction, supplies PC+2 for PCS, and implements the sticky HLT stop.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
DW, 16, PC and data width; fixed at 16 for this ISA

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
instr  input  16  instruction currently fetched at pc
stall  input  1  hold PC, flags and halt state this cycle
alu_z  input  1  ALU zero result for the current instruction
alu_v  input  1  ALU signed overflow for the current instruction
alu_n  input  1  ALU negative (result bit 15) for the current instruction
rs_data  input  16  register-file SrcData1 (instr[7:4]), used as the BR target
pc  output  16  fetch address (registered)
pc_plus2  output  16  pc + 2 modulo 2^16, written to rd by PCS
branch_taken  output  1  current instruction is B/BR and its condition passes
flags  output  3  {Z,V,N} flag register (registered)
hlt  output  1  processor halted

Behaviour:
- Reset (rst=1 at an edge): pc<=RESET_PC, flags<=3'b000, halted<=0. Reset overrides stall and halt, including mid-halt.
- Opcode decode on instr[15:12]:
  - 0000 ADD, 0001 SUB: flags write all of Z, V and N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: flags write Z only; V and N hold.
  - 0011, 0111, 1000-1011, 1100-1110: flags hold.
  - 1100 B, 1101 BR, 1110 PCS, 1111 HLT.
- Condition ccc=instr[11:9], evaluated against the registered flags, i.e. the flags written by earlier instructions, never the same-cycle alu_*:
  - 000 Z=0
  - 001 Z=1
  - 010 Z=0 & N=0
  - 011 N=1
  - 100 Z=1 | (Z=0 & N=0)
  - 101 N=1 | Z=1
  - 110 V=1
  - 111 always
- branch_taken (combinational) = (opcode is B or BR) & cond & !halted.
- Next PC:
  - halted, or opcode==HLT: pc holds.
  - B taken: pc_plus2 + (sign-extended instr[8:0] << 1), modulo 2^16.
  - BR taken: rs_data. No alignment correction; bit 0 passes through.
  - Otherwise, including a not-taken branch and PCS: pc_plus2.
  - Wrap-around: 16'hFFFE + 2 = 16'h0000, no error.
- Timing: single-cycle. The new pc is visible one clock after the instruction is presented. A taken branch produces no bubbles or delay slots.
- stall=1: pc, flags and halted all hold. branch_taken and pc_plus2 stay combinational and valid.
- HLT: hlt = (opcode==HLT & !rst) | halted. At the first non-stalled edge with opcode==HLT, halted<=1. Once halted, the block ignores instr, alu_* and rs_data, and only rst clears it.
- Simultaneous rst and HLT: reset wins, so halted=0 and hlt=0 at the next cycle.
- An HLT in the cycle with stall=1 raises hlt combinationally, but the sticky latch sets only on a non-stalled edge.

Optional Feature:
PC_PERF_CNT_EN
- Defined:
  - Adds output ports br_cnt[15:0] (B/BR instructions retired, taken or not) and taken_cnt[15:0] (taken branches).
  - Counters increment only on non-stalled, non-halted edges, saturate at 16'hFFFF, and clear on rst.
- Undefined: neither port nor any counter logic exists, and all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with RESET_PC=16'h0000 -> pc=0000, flags=000, hlt=0. Then NOPs (ADD) -> pc steps 0002, 0004, 0006.
- Flag update: SUB with alu_z=1, alu_v=0, alu_n=0 -> flags=100. Then XOR with alu_z=0, alu_n=1 -> flags=000, N unchanged at 0.
- B EQ forward: flags Z=1, pc=0010, B ccc=001 imm=9'h004 -> branch_taken=1, next pc=001A. Same with Z=0 -> next pc=0012.
- B backward wrap: pc=0000, B ccc=111 imm=9'h1FF -> next pc=0000. BR ccc=111 with rs_data=1234 -> next pc=1234.
- Stall: stall=1 for 3 cycles during an ADD at pc=0008 -> pc stays 0008 and flags unchanged. Release -> pc=000A.
- HLT: HLT at pc=0020 -> hlt=1 in the same cycle and pc stays 0020 for 5 cycles despite instr changing. Assert rst -> pc=0000, hlt=0.
